// File: rtl/alpaca_ospfb_constants_pkg.sv
// Shared constants and types for the OSPFB front end.
// Default frame geometry and the pause-gate state encoding.
package alpaca_ospfb_constants_pkg;
  localparam int FFT_LEN = 64;
  localparam int DEC_FAC = 48;
  localparam int WIDTH   = 16;
  // Output cadence repeats once per frame of FFT_LEN slots.
  localparam int PERIOD  = FFT_LEN;
  localparam int PHASE_W = $clog2(FFT_LEN);

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } gate_state_t;
endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register with a sideband payload.
// o_adv is high whenever the register can take a new beat this cycle.
module axis_out_reg #(
  parameter int WIDTH  = 16,
  parameter int SIDE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [SIDE_W-1:0] i_side,
  input  logic              i_ready,
  output logic              o_adv,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_data,
  output logic [SIDE_W-1:0] o_side
);
  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [SIDE_W-1:0] r_side;

  assign o_adv   = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_side  = r_side;

  // Payload only moves on a load, so it stays put while a beat is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_side  <= '0;
    end else if (o_adv) begin
      r_valid <= i_load;
      if (i_load) begin
        r_data <= i_data;
        r_side <= i_side;
      end
    end
  end
endmodule

// File: rtl/ospfb_pause_gate.sv
// OSPFB input rate gate: accepts PAUSE samples per MAX_CNT-slot frame and
// stalls the source for the rest, forwarding beats through a registered stage.
module ospfb_pause_gate #(
  parameter int WIDTH   = alpaca_ospfb_constants_pkg::WIDTH,
  parameter int MAX_CNT = alpaca_ospfb_constants_pkg::FFT_LEN,
  parameter int PAUSE   = alpaca_ospfb_constants_pkg::DEC_FAC,
  parameter int START   = PAUSE - 1,
  localparam int PW     = $clog2(MAX_CNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_s_axis_tdata,
  input  logic             i_s_axis_tvalid,
  output logic             o_s_axis_tready,
  output logic [WIDTH-1:0] o_m_axis_tdata,
  output logic             o_m_axis_tvalid,
  input  logic             i_m_axis_tready,
  output logic [PW-1:0]    o_phase,
  output logic             o_frame_last,
  output logic             o_underflow,
  output logic             o_state,
  output logic [PW-1:0]    o_ctr
);
  import alpaca_ospfb_constants_pkg::*;

  if (MAX_CNT < 2 || PAUSE < 1 || PAUSE >= MAX_CNT || START < 0 || START >= MAX_CNT) begin : g_bad_cfg
    $error("ospfb_pause_gate: need MAX_CNT>=2, 1<=PAUSE<MAX_CNT, 0<=START<MAX_CNT");
  end

  localparam logic [PW-1:0] CTR_LAST   = PW'(MAX_CNT - 1);
  localparam logic [PW-1:0] CTR_START  = PW'(START);
  localparam logic [PW-1:0] PAUSE_V    = PW'(PAUSE);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE - 1);

  logic [PW-1:0] r_ctr;
  logic [PW-1:0] w_ctr_nxt;
  logic          r_underflow;
  logic          w_adv;
  logic          w_pass;
  logic          w_load;
  logic          w_ctr_adv;
  logic          w_uf_set;
  gate_state_t   w_state;
  logic [PW:0]   w_side_in;
  logic [PW:0]   w_side_out;

  // The phase counter is the gate state: PASS below PAUSE, HOLD above.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr       <= CTR_START;
      r_underflow <= 1'b0;
    end else begin
      r_ctr <= w_ctr_nxt;
      if (w_uf_set) r_underflow <= 1'b1;
    end
  end

  always_comb begin
    w_ctr_nxt = r_ctr;
    if (w_ctr_adv) w_ctr_nxt = (r_ctr == CTR_LAST) ? '0 : r_ctr + 1'b1;
  end

  // A PASS slot only consumes its phase when a sample arrives; HOLD slots
  // tick whenever the output register can move.
  always_comb begin
    w_pass          = (r_ctr < PAUSE_V);
    w_state         = w_pass ? PASS : HOLD;
    o_s_axis_tready = w_pass & w_adv;
    w_load          = w_pass & w_adv & i_s_axis_tvalid;
    w_uf_set        = w_pass & w_adv & ~i_s_axis_tvalid;
    w_ctr_adv       = w_adv & (~w_pass | i_s_axis_tvalid);
  end

  assign w_side_in = {r_ctr, (r_ctr == PAUSE_LAST)};

  axis_out_reg #(
    .WIDTH  (WIDTH),
    .SIDE_W (PW + 1)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (i_s_axis_tdata),
    .i_side  (w_side_in),
    .i_ready (i_m_axis_tready),
    .o_adv   (w_adv),
    .o_valid (o_m_axis_tvalid),
    .o_data  (o_m_axis_tdata),
    .o_side  (w_side_out)
  );

  assign o_phase      = w_side_out[PW:1];
  assign o_frame_last = w_side_out[0];
  assign o_underflow  = r_underflow;
  assign o_state      = w_state;
  assign o_ctr        = r_ctr;
endmodule

// File: tb/tb_ospfb_pause_gate.sv
// Bench for ospfb_pause_gate: default 64/48 gate plus a 12/9 instance,
// with a scoreboard of expected beats built from the driven source.
module tb_ospfb_pause_gate;
  import alpaca_ospfb_constants_pkg::*;

  localparam int W  = 16;
  localparam int M  = 64;
  localparam int D  = 48;
  localparam int ST = 47;
  localparam int PW = PHASE_W;
  localparam int M2 = 12;
  localparam int D2 = 9;
  localparam int PW2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [PW-1:0] phase;
  logic          frame_last;
  logic          underflow;
  logic          state;
  logic [PW-1:0] ctr;

  logic [W-1:0]   s2_tdata = 16'h5A5A;
  logic           s2_tready;
  logic [W-1:0]   m2_tdata;
  logic           m2_tvalid;
  logic [PW2-1:0] phase2;
  logic           last2;
  logic           uf2;
  logic           state2;
  logic [PW2-1:0] ctr2;

  ospfb_pause_gate #(.WIDTH(W), .MAX_CNT(M), .PAUSE(D), .START(ST)) dut (
    .clk(clk), .rst(rst),
    .i_s_axis_tdata(s_tdata), .i_s_axis_tvalid(s_tvalid), .o_s_axis_tready(s_tready),
    .o_m_axis_tdata(m_tdata), .o_m_axis_tvalid(m_tvalid), .i_m_axis_tready(m_tready),
    .o_phase(phase), .o_frame_last(frame_last), .o_underflow(underflow),
    .o_state(state), .o_ctr(ctr)
  );

  ospfb_pause_gate #(.WIDTH(W), .MAX_CNT(M2), .PAUSE(D2), .START(0)) dut2 (
    .clk(clk), .rst(rst),
    .i_s_axis_tdata(s2_tdata), .i_s_axis_tvalid(1'b1), .o_s_axis_tready(s2_tready),
    .o_m_axis_tdata(m2_tdata), .o_m_axis_tvalid(m2_tvalid), .i_m_axis_tready(1'b1),
    .o_phase(phase2), .o_frame_last(last2), .o_underflow(uf2),
    .o_state(state2), .o_ctr(ctr2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W+PW:0] exp_q[$];
  int src_idx = 0;
  logic [PW-1:0] exp_ph = PW'(ST);
  bit ramp = 1'b0;
  int beats = 0;
  int ones = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] src_data(input int idx);
    if (ramp) return W'(idx);
    return (idx % 64 == 49) ? W'(1) : W'(0);
  endfunction

  // Drive one cycle's inputs at negedge, then score the handshakes that the
  // coming posedge will complete.
  task automatic step(input logic r, input logic vld, input logic rdy);
    logic [W+PW:0] e;
    @(negedge clk);
    rst      = r;
    s_tvalid = vld;
    m_tready = rdy;
    s_tdata  = src_data(src_idx);
    #1;
    if (!r) begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("sb_underrun", 32'(m_tvalid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 32'(m_tdata), 32'(e[W+PW:PW+1]));
          check("sb_phase", 32'(phase), 32'(e[PW:1]));
          check("sb_last", 32'(frame_last), 32'(e[0]));
          if (m_tdata == W'(1)) ones++;
          beats++;
        end
      end
      if (s_tvalid && s_tready) begin
        exp_q.push_back({s_tdata, exp_ph, (exp_ph == PW'(D - 1))});
        exp_ph = (exp_ph == PW'(D - 1)) ? '0 : exp_ph + 1'b1;
        src_idx++;
      end
    end
  endtask

  task automatic reset_bench();
    exp_q.delete();
    src_idx = 0;
    exp_ph  = PW'(ST);
    beats   = 0;
    ones    = 0;
  endtask

  // Continuous flow from reset; step k observes the state after posedge k-1.
  task automatic cadence(input int ncyc);
    int c;
    bit exp_v;
    for (int k = 0; k < ncyc; k++) begin
      step(1'b0, 1'b1, 1'b1);
      if (k == 0) begin
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_last", 32'(frame_last), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd1);
        check("rst_ctr", 32'(ctr), 32'(ST));
        check("rst_state", 32'(state), 32'(PASS));
      end else if (k <= 140) begin
        c = k - 1;
        exp_v = ((c % 64) == 0) || ((c % 64) >= 17);
        check("cad_tvalid", 32'(m_tvalid), 32'(exp_v));
      end
    end
  endtask

  initial begin
    int guard;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    reset_bench();

    // Impulse source, free flow: cadence and impulse position.
    ramp = 1'b0;
    cadence(270);
    check("imp_ones", 32'(ones), 32'd3);
    check("imp_enough_beats", 32'(beats > 177), 32'd1);
    check("imp_underflow", 32'(underflow), 32'd0);

    // Sink back-pressure mid-PASS with a counting ramp.
    ramp = 1'b1;
    guard = 0;
    while (!(m_tvalid && phase == PW'(20)) && guard < 200) begin
      step(1'b0, 1'b1, 1'b1);
      guard++;
    end
    check("bp_reach", 32'(phase), 32'd20);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("bp_tready", 32'(s_tready), 32'd0);
      check("bp_tvalid", 32'(m_tvalid), 32'd1);
      check("bp_qsize", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        check("bp_tdata", 32'(m_tdata), 32'(exp_q[0][W+PW:PW+1]));
        check("bp_phase", 32'(phase), 32'(exp_q[0][PW:1]));
        check("bp_ctr", 32'(ctr), 32'(exp_q[0][PW:1]) + 32'd1);
      end
    end
    repeat (40) step(1'b0, 1'b1, 1'b1);

    // Source gap of 3 slots at phase 10.
    guard = 0;
    while (!(ctr == PW'(9) && s_tready) && guard < 200) begin
      step(1'b0, 1'b1, 1'b1);
      guard++;
    end
    check("uf_reach", 32'(ctr), 32'd9);
    check("uf_before", 32'(underflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check("uf_ctr_hold", 32'(ctr), 32'd10);
    end
    step(1'b0, 1'b1, 1'b1);
    check("uf_set", 32'(underflow), 32'd1);
    check("uf_resume_ctr", 32'(ctr), 32'd10);
    repeat (130) step(1'b0, 1'b1, 1'b1);
    check("uf_sticky", 32'(underflow), 32'd1);

    // Reset while a beat at phase 30 is pending.
    guard = 0;
    while (!(m_tvalid && phase == PW'(29)) && guard < 200) begin
      step(1'b0, 1'b1, 1'b1);
      guard++;
    end
    step(1'b1, 1'b0, 1'b0);
    check("mrst_tvalid_before", 32'(m_tvalid), 32'd1);
    check("mrst_phase_before", 32'(phase), 32'd30);
    reset_bench();
    ramp = 1'b0;
    cadence(142);
    check("mrst_underflow", 32'(underflow), 32'd0);

    // Non-power-of-two 12/9 instance, continuous flow.
    step(1'b1, 1'b0, 1'b0);
    reset_bench();
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 1'b1);
      if (k == 0) begin
        check("np_rst_tvalid", 32'(m2_tvalid), 32'd0);
        check("np_rst_ctr", 32'(ctr2), 32'd0);
      end else begin
        check("np_tvalid", 32'(m2_tvalid), 32'(((k - 1) % M2) < D2));
        check("np_ctr", 32'(ctr2), 32'(k % M2));
        if (((k - 1) % M2) < D2) begin
          check("np_phase", 32'(phase2), 32'((k - 1) % M2));
          check("np_last", 32'(last2), 32'(((k - 1) % M2) == D2 - 1));
          check("np_tdata", 32'(m2_tdata), 32'h5A5A);
        end
      end
    end
    check("np_underflow", 32'(uf2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
